sync_down_counter: RTL and testbench



---
 rtl/sync_down_counter.sv | 107 ++++++++++
 tb/tb_sync_down_counter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_down_counter.sv
// Synchronous loadable down counter / countdown timer.
// Free-runs with a borrow pulse in IDLE, counts down to a tc pulse in RUN.
module sync_down_counter #(
    parameter int N = 4
) (
    input  logic         Ck,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] D,
    input  logic         T,
    input  logic         auto,
    output logic [N-1:0] Q,
    output logic         tc,
    output logic         borrow,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_t       state;
    state_t       state_nxt;
    logic [N-1:0] r;
    logic [N-1:0] r_nxt;
    logic [N-1:0] q_nxt;
    logic         tc_nxt;
    logic         borrow_nxt;
    logic         busy_nxt;

    always_ff @(negedge Ck) begin
        if (reset) begin
            state  <= IDLE;
            Q      <= '0;
            r      <= '0;
            tc     <= 1'b0;
            borrow <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_nxt;
            Q      <= q_nxt;
            r      <= r_nxt;
            tc     <= tc_nxt;
            borrow <= borrow_nxt;
            busy   <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        r_nxt      = r;
        q_nxt      = Q;
        tc_nxt     = 1'b0;
        borrow_nxt = 1'b0;
        if (load) begin
            r_nxt = D;
            q_nxt = D;
            if (D != '0) begin
                state_nxt = RUN;
            end else begin
                state_nxt = DONE;
                tc_nxt    = 1'b1;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (T) begin
                        if (Q != '0) begin
                            q_nxt = Q - ONE;
                        end else begin
                            q_nxt      = '1;
                            borrow_nxt = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (T) begin
                        // Q==0 is unreachable in RUN; treat it as terminal
                        if (Q > ONE) begin
                            q_nxt = Q - ONE;
                        end else begin
                            tc_nxt = 1'b1;
                            if (auto) begin
                                q_nxt = r;
                            end else begin
                                q_nxt     = '0;
                                state_nxt = DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    q_nxt = '0;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
        busy_nxt = (state_nxt == RUN);
    end

endmodule

// File: tb/tb_sync_down_counter.sv
// Scoreboard bench for sync_down_counter (N=4).
// Expected tuples are queued at drive time and checked after each negedge.
module tb_sync_down_counter;

    localparam int N = 4;

    logic         Ck = 1'b0;
    logic         reset;
    logic         load;
    logic [N-1:0] D;
    logic         T;
    logic         auto;
    logic [N-1:0] Q;
    logic         tc;
    logic         borrow;
    logic         busy;

    typedef struct packed {
        logic [3:0] q;
        logic       tc;
        logic       br;
        logic       busy;
    } obs_t;

    obs_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 Ck = ~Ck;

    sync_down_counter #(.N(N)) dut (
        .Ck    (Ck),
        .reset (reset),
        .load  (load),
        .D     (D),
        .T     (T),
        .auto  (auto),
        .Q     (Q),
        .tc    (tc),
        .borrow(borrow),
        .busy  (busy)
    );

    function automatic obs_t mk(int q, bit t, bit b, bit y);
        obs_t o;
        o.q    = q[3:0];
        o.tc   = t;
        o.br   = b;
        o.busy = y;
        return o;
    endfunction

    function automatic string show(obs_t o);
        return $sformatf("q=%0d tc=%b br=%b busy=%b",
                         o.q, o.tc, o.br, o.busy);
    endfunction

    // Inputs change on posedge, DUT updates on negedge, sample on posedge.
    task automatic drive(bit rs, bit ld, int d, bit t, bit a, obs_t e);
        reset = rs;
        load  = ld;
        D     = d[3:0];
        T     = t;
        auto  = a;
        sb.push_back(e);
        @(negedge Ck);
        @(posedge Ck);
    endtask

    task automatic test_reset();
        obs_t g, e;
        for (int i = 0; i < 2; i++) begin
            drive(1, i == 1, 9, 1, 1, mk(0, 0, 0, 0));
            g = {Q, tc, borrow, busy};
            e = sb.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL reset[%0d] got %s exp %s", i, show(g), show(e));
            end
        end
    endtask

    task automatic test_free_run();
        obs_t g, e;
        int   q;
        for (int k = 1; k <= 18; k++) begin
            q = (32 - k) % 16;
            drive(0, 0, 0, 1, 0, mk(q, 0, q == 15, 0));
            g = {Q, tc, borrow, busy};
            e = sb.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL free_run[%0d] got %s exp %s", k, show(g), show(e));
            end
        end
    endtask

    task automatic test_oneshot();
        obs_t g, e;
        for (int i = 0; i < 9; i++) begin
            drive(0, i == 0, 5, 1, 0,
                  mk(i <= 5 ? 5 - i : 0, i == 5, 0, i < 5));
            g = {Q, tc, borrow, busy};
            e = sb.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL oneshot[%0d] got %s exp %s", i, show(g), show(e));
            end
        end
    endtask

    task automatic test_auto_reload();
        obs_t g, e;
        bit   a;
        for (int i = 0; i < 9; i++) begin
            a = (i == 0) || (i % 3 == 0);
            drive(0, i == 0, 3, 1, a,
                  mk(3 - (i % 3), i > 0 && i % 3 == 0, 0, 1));
            g = {Q, tc, borrow, busy};
            e = sb.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL auto[%0d] got %s exp %s", i, show(g), show(e));
            end
        end
    endtask

    task automatic test_gated_count();
        bit   tv[8] = '{0, 1, 0, 1, 0, 1, 1, 1};
        obs_t g, e;
        int   cnt;
        bit   fire;
        for (int i = 0; i < 8; i++) begin
            fire = 0;
            if (i == 0) begin
                cnt = 4;
            end else if (tv[i] && cnt > 0) begin
                fire = (cnt == 1);
                cnt--;
            end
            drive(0, i == 0, 4, tv[i], 0, mk(cnt, fire, 0, cnt > 0));
            g = {Q, tc, borrow, busy};
            e = sb.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL gated[%0d] got %s exp %s", i, show(g), show(e));
            end
        end
    endtask

    task automatic test_zero_load();
        int   ld[5] = '{1, 0, 1, 0, 0};
        int   dv[5] = '{0, 0, 2, 0, 0};
        int   eq[5] = '{0, 0, 2, 1, 0};
        int   et[5] = '{1, 0, 0, 0, 1};
        int   ey[5] = '{0, 0, 1, 1, 0};
        obs_t g, e;
        for (int i = 0; i < 5; i++) begin
            drive(0, ld[i] != 0, dv[i], 1, 0,
                  mk(eq[i], et[i] != 0, 0, ey[i] != 0));
            g = {Q, tc, borrow, busy};
            e = sb.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL zero_load[%0d] got %s exp %s", i, show(g), show(e));
            end
        end
    endtask

    task automatic test_reset_abort();
        int   rs[7] = '{0, 0, 0, 0, 0, 1, 0};
        int   eq[7] = '{6, 5, 4, 3, 2, 0, 15};
        int   eb[7] = '{0, 0, 0, 0, 0, 0, 1};
        int   ey[7] = '{1, 1, 1, 1, 1, 0, 0};
        obs_t g, e;
        for (int i = 0; i < 7; i++) begin
            drive(rs[i] != 0, i == 0, 6, 1, 0,
                  mk(eq[i], 0, eb[i] != 0, ey[i] != 0));
            g = {Q, tc, borrow, busy};
            e = sb.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL reset_abort[%0d] got %s exp %s", i, show(g), show(e));
            end
        end
    endtask

    task automatic test_load_at_terminal();
        int   ld[3] = '{1, 1, 0};
        int   dv[3] = '{1, 7, 0};
        int   eq[3] = '{1, 7, 6};
        obs_t g, e;
        for (int i = 0; i < 3; i++) begin
            drive(0, ld[i] != 0, dv[i], 1, 0, mk(eq[i], 0, 0, 1));
            g = {Q, tc, borrow, busy};
            e = sb.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL load_term[%0d] got %s exp %s", i, show(g), show(e));
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t g, e;
        bit   t;
        for (int i = 0; i < 5; i++) begin
            t = (i < 4);
            drive(0, i == 0, 1, t, 1, mk(1, i > 0 && t, 0, 1));
            g = {Q, tc, borrow, busy};
            e = sb.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL b2b[%0d] got %s exp %s", i, show(g), show(e));
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        load  = 1'b0;
        D     = '0;
        T     = 1'b0;
        auto  = 1'b0;
        @(posedge Ck);
        test_reset();
        test_free_run();
        test_oneshot();
        test_auto_reload();
        test_gated_count();
        test_zero_load();
        test_reset_abort();
        test_load_at_terminal();
        test_back_to_back();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard left=%0d exp 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
